interp1d_lut: RTL and testbench
===============================

// Module: interp1d_lut
// PURPOSE
//  Parametrised, writable 1-D lookup table with linear interpolation between adjacent entries.
//  Input is an unsigned fixed-point coordinate (integer index + fraction); output is a signed interpolated value.
//  Out-of-range indices are clamped to the last entry and flagged, never read past the table.
//  Sits on a valid/ready stream between a coordinate generator and downstream DSP.
// PARAMETERS
//  DATA_W  16  width of LUT entries and out_y (signed two's complement)
//  IDX_W   8   integer index bits of in_x
//  FRAC_W  8   fractional bits of in_x
//  DEPTH   16  number of LUT entries; legal range 2 <= DEPTH <= 2**IDX_W
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               async active-low reset
//  wr_en      in   1               LUT write strobe
//  wr_addr    in   IDX_W           write index; wr_addr >= DEPTH ignored
//  wr_data    in   DATA_W          signed write value
//  in_valid   in   1               coordinate valid
//  in_ready   out  1               block accepts coordinate
//  in_x       in   IDX_W+FRAC_W    {index i, fraction f}, unsigned
//  out_valid  out  1               result valid
//  out_ready  in   1               downstream accepts result
//  out_y      out  DATA_W          interpolated result, signed
//  out_oor    out  1               coordinate was out of range (clamped)
// BEHAVIOUR
//  - Reset (async assert, sync-released by system): all LUT entries 0, all stage valids 0,
//    out_y 0, out_oor 0, out_valid 0. Reset mid-stream discards in-flight samples.
//  - 3-stage pipeline, single global enable adv = !out_valid | out_ready; in_ready = adv.
//    Transfer on in_valid & in_ready. Latency 3 cycles with out_ready held high; 1 sample/cycle.
//  - out_ready low with out_valid high: all stages hold, out_y/out_oor stable, no loss, order kept.
//  - S1 fetch: y0 = lut[i], y1 = lut[i+1], register f.
//      i <  DEPTH-1            : normal, oor = 0
//      i == DEPTH-1, f == 0    : y0 = y1 = lut[DEPTH-1], oor = 0
//      i == DEPTH-1, f != 0    : y0 = y1 = lut[DEPTH-1], oor = 1
//      i >  DEPTH-1            : y0 = y1 = lut[DEPTH-1], oor = 1
//  - S2: d = y1 - y0 at DATA_W+1 signed; p = d * $signed({1'b0,f}) at DATA_W+FRAC_W+2 bits.
//  - S3: out_y = y0 + (p >>> FRAC_W) (arithmetic shift, truncation toward -inf).
//    The result always lies between y0 and y1, so no saturation logic exists.
//  - Writes: take effect on the clock edge; an S1 fetch in the same cycle as a write to that
//    entry returns the OLD value. Writes are independent of the stream and of stalls.
//    wr_addr >= DEPTH: no state change.
//  - No X may reach out_y for any in_x value, including an all-ones index.
// CONFIGURATION
//  INTERP1D_ROUND_EN defined : S3 out_y = y0 + ((p + 2**(FRAC_W-1)) >>> FRAC_W) (round half up).
//  INTERP1D_ROUND_EN absent  : truncating arithmetic shift as above. Latency and ports identical.
// TESTING  (defaults DATA_W=16, IDX_W=8, FRAC_W=8, DEPTH=16)
//  - Write lut[3]=100, lut[4]=200; in_x=0x0380 -> out_y=150, out_oor=0, exactly 3 cycles after accept.
//  - lut[15]=-7; in_x=0x1400 (i=20) -> out_y=-7, oor=1; in_x=0x0F00 -> -7, oor=0; in_x=0x0F01 -> -7, oor=1.
//  - lut[0]=0, lut[1]=-3, in_x=0x0080 -> out_y=-2 without macro, -1 with INTERP1D_ROUND_EN.
//  - Issue 4 back-to-back coordinates with out_ready=0 for 5 cycles -> in_ready drops,
//    all 4 results emerge in order with no duplicate or loss.
//  - Write lut[3]=500 in the same cycle an in_x=0x0300 is accepted -> old value returned;
//    the next sample returns 500.
//  - Assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately, LUT reads 0 after release.

Source files
------------

// File: rtl/interp1d_lut.sv
// rtl/interp1d_lut.sv - writable 1-D LUT with 3-stage linear interpolation on a valid/ready stream
// Optional build macro: INTERP1D_ROUND_EN selects round-half-up instead of truncation in the last stage.
module interp1d_lut #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W+FRAC_W-1:0]   in_x,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_y,
    output logic                      out_oor
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = DATA_W + FRAC_W + 2;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_V = (IDX_W + 1)'(DEPTH);

    logic signed [DATA_W-1:0] lut [DEPTH];

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [IDX_W-1:0]  x_i;
    logic [FRAC_W-1:0] x_f;
    logic [AW-1:0]     rd0, rd1;
    logic              in_range, oor_c;
    assign x_i      = in_x[IDX_W+FRAC_W-1:FRAC_W];
    assign x_f      = in_x[FRAC_W-1:0];
    assign in_range = x_i < LAST;
    // Clamp both read indices so the array is never addressed past its last entry.
    assign rd0      = in_range ? AW'(x_i) : AW'(DEPTH - 1);
    assign rd1      = in_range ? AW'(x_i + 1'b1) : AW'(DEPTH - 1);
    assign oor_c    = (x_i > LAST) || ((x_i == LAST) && (x_f != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) lut[k] <= '0;
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_V)) begin
            lut[AW'(wr_addr)] <= wr_data;
        end
    end

    logic                     s1_valid, s1_oor;
    logic signed [DATA_W-1:0] s1_y0, s1_y1;
    logic [FRAC_W-1:0]        s1_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_y0    <= '0;
            s1_y1    <= '0;
            s1_f     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_oor   <= oor_c;
            s1_y0    <= lut[rd0];
            s1_y1    <= lut[rd1];
            s1_f     <= x_f;
        end
    end

    logic signed [DATA_W:0]   d;
    logic signed [FRAC_W:0]   fs;
    logic signed [PW-1:0]     p_c;
    assign d   = {s1_y1[DATA_W-1], s1_y1} - {s1_y0[DATA_W-1], s1_y0};
    assign fs  = {1'b0, s1_f};
    assign p_c = PW'(d) * PW'(fs);

    logic                     s2_valid, s2_oor;
    logic signed [DATA_W-1:0] s2_y0;
    logic signed [PW-1:0]     s2_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_oor   <= 1'b0;
            s2_y0    <= '0;
            s2_p     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_oor   <= s1_oor;
            s2_y0    <= s1_y0;
            s2_p     <= p_c;
        end
    end

    logic signed [PW-1:0]     p_adj;
    logic signed [DATA_W-1:0] q, y_c;
`ifdef INTERP1D_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);
    assign p_adj = s2_p + HALF;
`else
    assign p_adj = s2_p;
`endif
    // Interpolated value stays between y0 and y1, so the narrowing cast cannot overflow.
    assign q   = DATA_W'(p_adj >>> FRAC_W);
    assign y_c = s2_y0 + q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_oor   <= 1'b0;
            out_y     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_oor   <= s2_oor;
            out_y     <= y_c;
        end
    end
endmodule

// File: tb/tb_interp1d_lut.sv
// tb/tb_interp1d_lut.sv - self-checking bench for interp1d_lut with a behavioural LUT model
module tb_interp1d_lut;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic        out_oor;

    interp1d_lut #(.DATA_W(16), .IDX_W(8), .FRAC_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_oor(out_oor)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_lat = 0;
    logic signed [31:0] got_y;
    logic               got_oor;
    logic               stall_prev = 1'b0;
    logic [15:0]        held_y;
    logic               saw_busy = 1'b0;

    int m_lut [16];
    int exp_y_q [$];
    bit exp_o_q [$];
    int acc_q [$];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div256(input int p);
        int q;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int model_y(input int x, output bit oor);
        int i, f, y0, y1, p;
        i = x / 256;
        f = x % 256;
        if (i < 15) begin
            y0 = m_lut[i]; y1 = m_lut[i+1]; oor = 1'b0;
        end else begin
            y0 = m_lut[15]; y1 = m_lut[15]; oor = (i > 15) || (f != 0);
        end
        p = (y1 - y0) * f;
`ifdef INTERP1D_ROUND_EN
        p = p + 128;
`endif
        return y0 + floor_div256(p);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_y", $signed(out_y), $signed(held_y));
            end
            stall_prev <= out_valid && !out_ready;
            held_y     <= out_y;
            if (in_valid && !in_ready) saw_busy <= 1'b1;
            if (out_valid && out_ready) begin
                if (exp_y_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 0);
                end else begin
                    chk("model_y", $signed(out_y), exp_y_q.pop_front());
                    chk("model_oor", 32'(out_oor), 32'(exp_o_q.pop_front()));
                    last_lat <= cyc - acc_q.pop_front();
                end
                got_y   <= $signed(out_y);
                got_oor <= out_oor;
                out_cnt <= out_cnt + 1;
            end
            if (in_valid && in_ready) begin
                bit o;
                int y;
                y = model_y(int'(in_x), o);
                exp_y_q.push_back(y);
                exp_o_q.push_back(o);
                acc_q.push_back(cyc);
            end
            if (wr_en && wr_addr < 16) m_lut[wr_addr] <= $signed(wr_data);
        end
    end

    task automatic wr(input int a, input int v);
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = 16'(v);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic send(input int x);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_x = 16'(x);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_cnt >= n) begin ok = 1'b1; break; end
        end
        if (!ok) chk("out_timeout", out_cnt, n);
    endtask

    task automatic one(input string name, input int x, input int ey, input int eo);
        int n;
        n = out_cnt;
        send(x);
        wait_out(n + 1);
        chk({name, "_y"}, got_y, ey);
        chk({name, "_oor"}, 32'(got_oor), eo);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 16; k++) m_lut[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_y", $signed(out_y), 0);
        chk("rst_out_oor", 32'(out_oor), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        wr(3, 100); wr(4, 200);
        one("mid", 16'h0380, 150, 0);
        chk("latency", last_lat, 3);
        wr(5, -100);
        one("neg_slope", 16'h0440, 125, 0);
        wr(15, -7);
        one("idx20", 16'h1400, -7, 1);
        one("last_f0", 16'h0F00, -7, 0);
        one("last_f1", 16'h0F01, -7, 1);
        one("all_ones", 16'hFFFF, -7, 1);
        wr(16, 999); wr(255, 999);
        one("oob_write", 16'h0F00, -7, 0);
        wr(0, 0); wr(1, -3);
`ifdef INTERP1D_ROUND_EN
        one("round", 16'h0080, -1, 0);
`else
        one("trunc", 16'h0080, -2, 0);
`endif
        one("exact_entry", 16'h0400, 200, 0);

        n = out_cnt;
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 16'd500;
        send(16'h0300);
        wr_en = 1'b0;
        wait_out(n + 1);
        chk("wr_same_cycle_old", got_y, 100);
        one("wr_next_new", 16'h0300, 500, 0);

        n = out_cnt;
        saw_busy = 1'b0;
        fork
            begin
                send(16'h0380); send(16'h0440); send(16'h0200); send(16'h0F01);
            end
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_out(n + 4);
        chk("stall_busy", 32'(saw_busy), 1);
        chk("stall_count", out_cnt - n, 4);
        chk("stall_drained", exp_y_q.size(), 0);

        out_ready = 1'b0;
        send(16'h0380); send(16'h0440); send(16'h0300);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        exp_y_q.delete(); exp_o_q.delete(); acc_q.delete();
        for (int k = 0; k < 16; k++) m_lut[k] = 0;
        stall_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        one("post_rst_mid", 16'h0380, 0, 0);
        one("post_rst_last", 16'h0F00, 0, 0);
        repeat (4) @(posedge clk);
        chk("final_empty", exp_y_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
